alu_op_issuer: RTL and testbench

// - Request-side driver for the registered 4-op ALU (mul/add/div/sub with one-hot result select).
// - Accepts one operation request over a valid/ready handshake.
// - Drives the ALU operands and the one-hot select, waits out the ALU pipeline, and captures the result.
// - Returns the result over a valid/ready response channel.
// - Applies operand isolation: ALU operands and select are forced to 0 whenever no operation is in flight.

---
 rtl/alu_op_issuer.sv | 177 +++++++++++++++++
 tb/tb_alu_op_issuer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// Request-side driver for a registered 4-op ALU: one op in flight, operand isolation when idle.
// Optional feature macro: ALU_DIVZERO_CHK_EN (short-circuits divide-by-zero with an error response).
module alu_op_issuer #(
  parameter int DW      = 4,
  parameter int ALU_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DW-1:0]     req_a,
  input  logic [DW-1:0]     req_b,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [3:0]        alu_sel,
  input  logic [2*DW-1:0]   alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2*DW-1:0]   rsp_data,
  output logic [1:0]        rsp_op,
  output logic              rsp_err
);

  localparam int RW = 2 * DW;
  localparam int CW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic [3:0]      alu_sel_q, alu_sel_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [RW-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]      rsp_op_q, rsp_op_d;
`ifdef ALU_DIVZERO_CHK_EN
  logic            rsp_err_q, rsp_err_d;
`endif

  function automatic logic [3:0] op_to_sel(input logic [1:0] op);
    case (op)
      2'd0:    op_to_sel = 4'b1000;
      2'd1:    op_to_sel = 4'b0100;
      2'd2:    op_to_sel = 4'b0010;
      2'd3:    op_to_sel = 4'b0001;
      default: op_to_sel = 4'b0000;
    endcase
  endfunction

  // Next-state and next-output computation for the issue FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_op_d    = rsp_op_q;
`ifdef ALU_DIVZERO_CHK_EN
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rsp_op_d = req_op;
`ifdef ALU_DIVZERO_CHK_EN
          // Divide-by-zero never reaches the ALU; operands stay isolated
          if ((req_op == 2'd2) && (req_b == {DW{1'b0}})) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = {RW{1'b1}};
            rsp_err_d   = 1'b1;
          end else begin
            state_d   = ISSUE;
            cnt_d     = {CW{1'b0}};
            alu_a_d   = req_a;
            alu_b_d   = req_b;
            alu_sel_d = op_to_sel(req_op);
            rsp_err_d = 1'b0;
          end
`else
          state_d   = ISSUE;
          cnt_d     = {CW{1'b0}};
          alu_a_d   = req_a;
          alu_b_d   = req_b;
          alu_sel_d = op_to_sel(req_op);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        // Once the counter reaches ALU_LAT the ALU output register holds our result
        if (cnt_q == CW'(ALU_LAT)) begin
          rsp_data_d  = alu_out;
          rsp_valid_d = 1'b1;
          alu_a_d     = {DW{1'b0}};
          alu_b_d     = {DW{1'b0}};
          alu_sel_d   = 4'b0000;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        alu_a_d     = {DW{1'b0}};
        alu_b_d     = {DW{1'b0}};
        alu_sel_d   = 4'b0000;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset aborts any in-flight op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      alu_a_q     <= {DW{1'b0}};
      alu_b_q     <= {DW{1'b0}};
      alu_sel_q   <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {RW{1'b0}};
      rsp_op_q    <= 2'd0;
`ifdef ALU_DIVZERO_CHK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_op_q    <= rsp_op_d;
`ifdef ALU_DIVZERO_CHK_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_op    = rsp_op_q;
`ifdef ALU_DIVZERO_CHK_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed self-checking bench for alu_op_issuer with a behavioural 2-stage registered ALU.
module tb_alu_op_issuer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'd0;
  logic [3:0] req_a = 4'd0;
  logic [3:0] req_b = 4'd0;
  logic [3:0] alu_a, alu_b, alu_sel;
  logic [7:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [1:0] rsp_op;
  logic       rsp_err;

  int n_assert = 0;
  int n_fail   = 0;

  alu_op_issuer #(.DW(4), .ALU_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_op(rsp_op), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // ALU: operand register then result register
  logic [3:0] m_a, m_b, m_sel;
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
    case (sel)
      4'b1000: alu_fn = {4'd0, a} * {4'd0, b};
      4'b0100: alu_fn = {4'd0, a} + {4'd0, b};
      4'b0010: alu_fn = (b == 4'd0) ? 8'hFF : ({4'd0, a} / {4'd0, b});
      4'b0001: alu_fn = {4'd0, a} - {4'd0, b};
      default: alu_fn = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_a <= 4'd0; m_b <= 4'd0; m_sel <= 4'd0; alu_out <= 8'd0;
    end else begin
      m_a <= alu_a; m_b <= alu_b; m_sel <= alu_sel;
      alu_out <= alu_fn(m_a, m_b, m_sel);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);

    // mul 15*15
    req_valid = 1'b1; req_op = 2'd0; req_a = 4'd15; req_b = 4'd15;
    tick();
    req_valid = 1'b0; req_a = 4'd0; req_b = 4'd0;
    chk("mul_T_sel", alu_sel, 4'b1000);
    chk("mul_T_a", alu_a, 15);
    chk("mul_T_ready", req_ready, 0);
    tick();
    chk("mul_T1_sel", alu_sel, 4'b1000);
    chk("mul_T1_valid", rsp_valid, 0);
    tick();
    chk("mul_T2_sel", alu_sel, 4'b1000);
    chk("mul_T2_valid", rsp_valid, 0);
    tick();
    chk("mul_T3_valid", rsp_valid, 1);
    chk("mul_data", rsp_data, 8'hE1);
    chk("mul_op", rsp_op, 0);
    chk("mul_iso_sel", alu_sel, 0);
    chk("mul_iso_a", alu_a, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("mul_done_valid", rsp_valid, 0);
    chk("mul_done_ready", req_ready, 1);

    // add 9+8 then sub 3-5 held valid back-to-back
    req_valid = 1'b1; req_op = 2'd1; req_a = 4'd9; req_b = 4'd8;
    tick();
    req_op = 2'd3; req_a = 4'd3; req_b = 4'd5;
    chk("add_sel", alu_sel, 4'b0100);
    tick();
    chk("add_busy1", req_ready, 0);
    tick();
    chk("add_busy2", req_ready, 0);
    tick();
    chk("add_valid", rsp_valid, 1);
    chk("add_data", rsp_data, 8'h11);
    chk("add_op", rsp_op, 1);
    chk("add_busy3", req_ready, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("add_done_valid", rsp_valid, 0);
    chk("add_done_ready", req_ready, 1);
    chk("sub_not_yet_sel", alu_sel, 0);
    tick();
    req_valid = 1'b0;
    chk("sub_sel", alu_sel, 4'b0001);
    tick(); tick(); tick();
    chk("sub_valid", rsp_valid, 1);
    chk("sub_data", rsp_data, 8'hFE);
    chk("sub_op", rsp_op, 3);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("sub_done_valid", rsp_valid, 0);

    // div 13/4 with consumer stalled for 5 cycles
    req_valid = 1'b1; req_op = 2'd2; req_a = 4'd13; req_b = 4'd4;
    tick();
    req_valid = 1'b0;
    chk("div_sel", alu_sel, 4'b0010);
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("div_hold_valid", rsp_valid, 1);
      chk("div_hold_data", rsp_data, 8'h03);
      chk("div_hold_op", rsp_op, 2);
      tick();
    end
    chk("div_hold_last", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("div_done_valid", rsp_valid, 0);
    chk("div_done_ready", req_ready, 1);

    // div 7/0
    req_valid = 1'b1; req_op = 2'd2; req_a = 4'd7; req_b = 4'd0;
    tick();
    req_valid = 1'b0;
`ifdef ALU_DIVZERO_CHK_EN
    chk("dz_valid", rsp_valid, 1);
    chk("dz_data", rsp_data, 8'hFF);
    chk("dz_err", rsp_err, 1);
    chk("dz_sel", alu_sel, 0);
    chk("dz_a", alu_a, 0);
`else
    chk("dz_sel", alu_sel, 4'b0010);
    chk("dz_early_valid", rsp_valid, 0);
    tick(); tick(); tick();
    chk("dz_valid", rsp_valid, 1);
    chk("dz_data", rsp_data, 8'hFF);
    chk("dz_err", rsp_err, 0);
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("dz_done_valid", rsp_valid, 0);

    // mul 2*3 aborted by reset during WAIT
    req_valid = 1'b1; req_op = 2'd0; req_a = 4'd2; req_b = 4'd3;
    tick();
    req_valid = 1'b0;
    tick();
    chk("abort_pre_sel", alu_sel, 4'b1000);
    rst = 1'b0;
    #1;
    chk("abort_sel", alu_sel, 0);
    chk("abort_a", alu_a, 0);
    chk("abort_b", alu_b, 0);
    chk("abort_valid", rsp_valid, 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_rsp", rsp_valid, 0);
    end
    chk("abort_ready", req_ready, 1);

    // add 1+1 after abort
    req_valid = 1'b1; req_op = 2'd1; req_a = 4'd1; req_b = 4'd1;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    chk("post_valid", rsp_valid, 1);
    chk("post_data", rsp_data, 8'h02);
    chk("post_op", rsp_op, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_done", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
